round_pipe: RTL and testbench
=============================

# round_pipe

Pipelined, multi-mode rounding unit for the divide/square-root datapath. It takes an unrounded magnitude with guard bits, plus the sign and the remainder status of the final iteration. It produces an IEEE-style rounded magnitude in one of five rounding modes, with inexact and carry-out flags. It replaces the per-mode combinational rounders with one parametrised, two-stage, valid/ready block that sits between the iteration engine and the normaliser/packer.

## Interface
Parameters:
- WIDTH, 28: magnitude width, including guard bits.
- ULP, 4: number of low guard bits below the kept LSB. Must be ≥ 2 and < WIDTH.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- in_valid, in, 1: input transaction valid.
- in_ready, out, 1: block can accept a transaction.
- x, in, WIDTH: unrounded magnitude.
- sign, in, 1: result sign (1 = negative).
- rem_neg, in, 1: true value is below x.
- rem_zero, in, 1: true value equals x. Takes priority over rem_neg.
- mode, in, 3: rounding mode. 0 = RNE, 1 = RZ, 2 = RDN (toward −inf), 3 = RUP (toward +inf), 4 = RNA (nearest, ties away). Values 5–7 behave as RZ.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- y, out, WIDTH: rounded magnitude; y[ULP-1:0] is always 0.
- y_sign, out, 1: sign passed through.
- inexact, out, 1: the result differs from the true value.
- carry_out, out, 1: the increment overflowed WIDTH.
- inexact_cnt, out, 16: saturating count of inexact results (see Configuration).

## Operation
Stage 1 (adjust), on accept (in_valid & in_ready):
- If rem_zero: xa = x, rs = 0.
- Else if rem_neg: xa = x − 1 (WIDTH-bit wrap), rs = 1.
- Else: xa = x, rs = 1.
- G = xa[ULP-1]; S = |xa[ULP-2:0] | rs; L = xa[ULP].
- Register xa[WIDTH-1:ULP], G, S, L, sign and mode.

Stage 2 (round):
- inc is decided per mode:
  - RNE: G & (S | L).
  - RZ: 0.
  - RDN: sign & (G | S).
  - RUP: ~sign & (G | S).
  - RNA: G.
- {carry_out, q} = xa[WIDTH-1:ULP] + inc, computed at WIDTH−ULP+1 bits.
- y = {q, ULP zeros}; on carry_out, q is 0.
- inexact = G | S.
- mode, sign and flags travel with their own data; there is no cross-transaction state except inexact_cnt.

Handshake:
- Stage 1 and stage 2 each hold one valid bit.
- A stage loads when it is empty or its contents advance this cycle.
- in_ready = ~s1_valid | s2_can_load, where s2_can_load = ~out_valid | out_ready.
- A result is transferred on out_valid & out_ready.
- in_ready does not depend combinationally on in_valid.
- Data on y, y_sign, inexact and carry_out holds stable while out_valid & ~out_ready.

## Timing
- All outputs are registered.
- Latency: 2 cycles. A transaction accepted at edge N gives out_valid at edge N+2 when unstalled.
- Throughput: 1 transaction per cycle with out_ready held high.
- Full: both stages valid and out_ready low, so in_ready = 0. in_ready returns 1 in the cycle out_ready is sampled high; no bubble is inserted.
- Simultaneous accept and drain in the same cycle is legal at both stages.
- Reset: with rst_n low at an edge, both valid bits clear and all in-flight transactions are discarded. After that edge:
  - out_valid, y, y_sign, inexact, carry_out and inexact_cnt are 0.
  - in_ready is 1 from the first cycle after reset deasserts.

## Configuration
- ROUND_INEXACT_CNT_EN defined: inexact_cnt increments by 1 on each output transfer with inexact = 1. It saturates at 0xFFFF and is cleared only by reset.
- ROUND_INEXACT_CNT_EN undefined: inexact_cnt is tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
All scenarios use WIDTH = 28 and ULP = 4.
- RNE ties: x = 0x0000018, rem_zero = 1 → y = 0x0000020, inexact = 1. x = 0x0000028, rem_zero = 1 → y = 0x0000020, inexact = 1.
- Negative remainder under RZ: x = 0x0000020, rem_neg = 1 → xa = 0x000001F, y = 0x0000010, inexact = 1. Same x with rem_zero = 1 → y = 0x0000020, inexact = 0.
- Directed modes, x = 0x0000011, rem_zero = 1:
  - RUP, sign = 0 → y = 0x0000020.
  - RUP, sign = 1 → y = 0x0000010.
  - RDN, sign = 1 → y = 0x0000020.
- Overflow: x = 0xFFFFFF8, RNE, rem_neg = 0, rem_zero = 0 → y = 0x0000000, carry_out = 1, inexact = 1.
- Backpressure: 4 back-to-back inputs with out_ready low for 3 cycles → exactly 2 accepted, then in_ready = 0. After out_ready rises, all 4 results emerge in order with no loss or duplication. With the macro defined and all 4 inexact, inexact_cnt = 4.
- Reset mid-stream: rst_n low for 1 cycle with 2 transactions in flight → out_valid = 0 and inexact_cnt = 0 after the edge. Neither transaction appears afterwards, and in_ready = 1 on the next cycle.

Source files
------------

// File: rtl/round_pipe_if.sv
// Handshake/data bundle between the divide/sqrt iteration engine, the
// rounding pipe and the normaliser/packer. The rounder is the slave side.
interface round_pipe_if #(
    parameter int WIDTH = 28
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic             sign;
    logic             rem_neg;
    logic             rem_zero;
    logic [2:0]       mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_sign;
    logic             inexact;
    logic             carry_out;
    logic [15:0]      inexact_cnt;

    modport master (
        output in_valid, x, sign, rem_neg, rem_zero, mode, out_ready,
        input  in_ready, out_valid, y, y_sign, inexact, carry_out, inexact_cnt
    );

    modport slave (
        input  in_valid, x, sign, rem_neg, rem_zero, mode, out_ready,
        output in_ready, out_valid, y, y_sign, inexact, carry_out, inexact_cnt
    );
endinterface

// File: rtl/round_pipe.sv
// round_pipe: two-stage valid/ready rounding unit for the divide/sqrt
// datapath. Stage 1 folds the remainder status into guard/sticky bits,
// stage 2 applies the selected rounding mode and registers the result.
// Optional macro ROUND_INEXACT_CNT_EN builds a saturating 16-bit counter
// of inexact results; without it inexact_cnt is tied to zero.
module round_pipe #(
    parameter int WIDTH = 28,
    parameter int ULP   = 4
) (
    input logic        clk,
    input logic        rst_n,
    round_pipe_if.slave bus
);

    localparam int QW = WIDTH - ULP;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RZ  = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RNA = 3'd4
    } round_mode_e;

    // handshake
    logic s2_can_load;
    logic in_ready;
    logic accept;
    logic s1_adv;

    // stage 1 (adjust) registers
    logic          s1_valid_q, s1_valid_d;
    logic [QW-1:0] s1_xh_q,    s1_xh_d;
    logic          s1_g_q,     s1_g_d;
    logic          s1_s_q,     s1_s_d;
    logic          s1_sign_q,  s1_sign_d;
    logic [2:0]    s1_mode_q,  s1_mode_d;

    // stage 2 (round) registers, which are the block outputs
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q,         y_d;
    logic             y_sign_q,    y_sign_d;
    logic             inexact_q,   inexact_d;
    logic             carry_q,     carry_d;

    // combinational datapath
    logic [WIDTH-1:0] xa;
    logic             rs;
    logic             inc;
    logic [QW:0]      sum;

    // Ready chain: a stage may load when empty or when it drains this cycle.
    always_comb begin
        s2_can_load = ~out_valid_q | bus.out_ready;
        in_ready    = ~s1_valid_q | s2_can_load;
        accept      = bus.in_valid & in_ready;
        s1_adv      = s1_valid_q & s2_can_load;
    end

    // Fold remainder status into the magnitude: below x means x-1 plus sticky.
    always_comb begin
        xa = bus.x;
        rs = 1'b1;
        if (bus.rem_zero) begin
            rs = 1'b0;
        end else if (bus.rem_neg) begin
            xa = bus.x - WIDTH'(1);
        end
    end

    // Stage 1 next state: capture kept bits, guard and sticky on accept.
    always_comb begin
        s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
        s1_xh_d    = s1_xh_q;
        s1_g_d     = s1_g_q;
        s1_s_d     = s1_s_q;
        s1_sign_d  = s1_sign_q;
        s1_mode_d  = s1_mode_q;
        if (accept) begin
            s1_xh_d   = xa[WIDTH-1:ULP];
            s1_g_d    = xa[ULP-1];
            s1_s_d    = (|xa[ULP-2:0]) | rs;
            s1_sign_d = bus.sign;
            s1_mode_d = bus.mode;
        end
    end

    // Rounding decision and increment; L is the lowest kept bit.
    always_comb begin
        inc = 1'b0;
        case (s1_mode_q)
            RNE:     inc = s1_g_q & (s1_s_q | s1_xh_q[0]);
            RZ:      inc = 1'b0;
            RDN:     inc = s1_sign_q & (s1_g_q | s1_s_q);
            RUP:     inc = ~s1_sign_q & (s1_g_q | s1_s_q);
            RNA:     inc = s1_g_q;
            default: inc = 1'b0;
        endcase
        sum = {1'b0, s1_xh_q} + {{QW{1'b0}}, inc};
    end

    // Stage 2 next state: outputs hold while stalled, reload when drained.
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_sign_d    = y_sign_q;
        inexact_d   = inexact_q;
        carry_d     = carry_q;
        if (s2_can_load) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            y_d       = {sum[QW-1:0], {ULP{1'b0}}};
            y_sign_d  = s1_sign_q;
            inexact_d = s1_g_q | s1_s_q;
            carry_d   = sum[QW];
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_xh_q     <= '0;
            s1_g_q      <= 1'b0;
            s1_s_q      <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_sign_q    <= 1'b0;
            inexact_q   <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_xh_q     <= s1_xh_d;
            s1_g_q      <= s1_g_d;
            s1_s_q      <= s1_s_d;
            s1_sign_q   <= s1_sign_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_sign_q    <= y_sign_d;
            inexact_q   <= inexact_d;
            carry_q     <= carry_d;
        end
    end

`ifdef ROUND_INEXACT_CNT_EN
    logic [15:0] inexact_cnt_q, inexact_cnt_d;

    // Count inexact results as they leave; sticks at all-ones.
    always_comb begin
        inexact_cnt_d = inexact_cnt_q;
        if (out_valid_q && bus.out_ready && inexact_q && (inexact_cnt_q != '1)) begin
            inexact_cnt_d = inexact_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inexact_cnt_q <= '0;
        end else begin
            inexact_cnt_q <= inexact_cnt_d;
        end
    end

    assign bus.inexact_cnt = inexact_cnt_q;
`else
    assign bus.inexact_cnt = '0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.y_sign    = y_sign_q;
    assign bus.inexact   = inexact_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_round_pipe.sv
// Self-checking bench for round_pipe: directed rounding cases, randomized
// traffic against an arithmetic reference model, throughput/latency,
// backpressure and mid-stream reset.
module tb_round_pipe;

    localparam int WIDTH = 28;
    localparam int ULP   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    round_pipe_if #(.WIDTH(WIDTH)) bus ();

    round_pipe #(.WIDTH(WIDTH), .ULP(ULP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             ys;
        logic             inx;
        logic             co;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   cnt_model = 0;

    // Reference: place the true value on a grid of quarter-units of x
    // (x-eps, x, x+eps), then snap to a multiple of 2^ULP by mode rules.
    function automatic res_t model(input logic [WIDTH-1:0] xv, input logic sg,
                                   input logic rn, input logic rz, input logic [2:0] md);
        longint t, step, lo, hi, rem, r, m;
        res_t   o;
        step = 4 * (longint'(1) << ULP);
        t    = 4 * longint'(xv) + (rz ? 0 : (rn ? -1 : 1));
        lo   = (t / step) * step;
        rem  = t - lo;
        hi   = lo + step;
        if (rem == 0) begin
            r = t;
        end else begin
            case (md)
                3'd0: begin
                    if (2 * rem < step)      r = lo;
                    else if (2 * rem > step) r = hi;
                    else                     r = (((lo / step) % 2) == 0) ? lo : hi;
                end
                3'd2:    r = sg ? hi : lo;
                3'd3:    r = sg ? lo : hi;
                3'd4:    r = (2 * rem < step) ? lo : hi;
                default: r = lo;
            endcase
        end
        m     = r / 4;
        o.co  = (m >= (longint'(1) << WIDTH));
        o.y   = WIDTH'(m);
        o.ys  = sg;
        o.inx = (rem != 0);
        return o;
    endfunction

    function automatic int exp_cnt();
`ifdef ROUND_INEXACT_CNT_EN
        return cnt_model;
`else
        return 0;
`endif
    endfunction

    // One clock: drive inputs at the negedge, record what the next posedge will accept/transfer.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] xv, input logic sg,
                         input logic rn, input logic rz, input logic [2:0] md,
                         input logic ordy, output logic acc, output logic xfr);
        int idx;
        bus.in_valid  = iv;
        bus.x         = xv;
        bus.sign      = sg;
        bus.rem_neg   = rn;
        bus.rem_zero  = rz;
        bus.mode      = md;
        bus.out_ready = ordy;
        #1;
        acc = iv && bus.in_ready;
        xfr = bus.out_valid && ordy;
        if (acc) exp_q.push_back(model(xv, sg, rn, rz, md));
        if (xfr) begin
            obs_q.push_back('{bus.y, bus.y_sign, bus.inexact, bus.carry_out});
            idx = obs_q.size() - 1;
            if (idx < exp_q.size() && exp_q[idx].inx && cnt_model < 65535) cnt_model++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic a, f;
        for (int i = 0; i < 30 && obs_q.size() < exp_q.size(); i++)
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, a, f);
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        cnt_model = 0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.sign      = 1'b0;
        bus.rem_neg   = 1'b0;
        bus.rem_zero  = 1'b0;
        bus.mode      = 3'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.y, bus.y_sign, bus.inexact, bus.carry_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b y=%h s=%b inx=%b co=%b want all 0",
                     bus.out_valid, bus.y, bus.y_sign, bus.inexact, bus.carry_out);
        end
        total++;
        if (bus.inexact_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt got %0d want 0", bus.inexact_cnt);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        exp_q.delete();
        obs_q.delete();
        cnt_model = 0;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] tx[10]  = '{28'h0000018, 28'h0000028, 28'h0000020, 28'h0000020, 28'h0000011,
                                      28'h0000011, 28'h0000011, 28'hFFFFFF8, 28'h000001F, 28'h0000028};
        logic             tsg[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
        logic             trn[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        logic             trz[10] = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
        logic [2:0]       tmd[10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd2, 3'd0, 3'd5, 3'd4};
        logic [WIDTH-1:0] ty[10]  = '{28'h0000020, 28'h0000020, 28'h0000010, 28'h0000020, 28'h0000020,
                                      28'h0000010, 28'h0000020, 28'h0000000, 28'h0000010, 28'h0000030};
        logic             tix[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        logic             tco[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic             a, f;
        res_t             want;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, tx[i], tsg[i], trn[i], trz[i], tmd[i], 1'b1, a, f);
        drain();
        total++;
        if (obs_q.size() != 10) begin
            bad++;
            $display("FAIL directed_count got %0d want 10", obs_q.size());
        end
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            want = '{ty[i], tsg[i], tix[i], tco[i]};
            total++;
            if (obs_q[i] !== want) begin
                bad++;
                $display("FAIL directed[%0d] got y=%h s=%b inx=%b co=%b want y=%h s=%b inx=%b co=%b",
                         i, obs_q[i].y, obs_q[i].ys, obs_q[i].inx, obs_q[i].co,
                         want.y, want.ys, want.inx, want.co);
            end
        end
        total++;
        if (int'(bus.inexact_cnt) != exp_cnt()) begin
            bad++;
            $display("FAIL directed_cnt got %0d want %0d", bus.inexact_cnt, exp_cnt());
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] xv;
        logic             rn, rz, a, f;
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < 300; c++) begin
            xv = WIDTH'($urandom);
            if ($urandom_range(7) == 0) xv = 28'hFFFFFF0 | WIDTH'($urandom_range(15));
            rz = ($urandom_range(3) == 0);
            rn = $urandom_range(1);
            if (rn && xv == '0) xv = WIDTH'(1);
            cycle($urandom_range(3) != 0, xv, 1'($urandom_range(1)), rn, rz,
                  3'($urandom_range(7)), $urandom_range(9) < 7, a, f);
        end
        drain();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random[%0d] got y=%h s=%b inx=%b co=%b want y=%h s=%b inx=%b co=%b",
                         i, obs_q[i].y, obs_q[i].ys, obs_q[i].inx, obs_q[i].co,
                         exp_q[i].y, exp_q[i].ys, exp_q[i].inx, exp_q[i].co);
            end
        end
        total++;
        if (int'(bus.inexact_cnt) != exp_cnt()) begin
            bad++;
            $display("FAIL random_cnt got %0d want %0d", bus.inexact_cnt, exp_cnt());
        end
    endtask

    task automatic test_back_to_back();
        logic a, f;
        int   acc_n = 0, first_acc = -1, first_xfr = -1;
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < 24; c++) begin
            cycle(c < 16, WIDTH'($urandom), 1'($urandom_range(1)), 1'b0,
                  1'($urandom_range(1)), 3'($urandom_range(4)), 1'b1, a, f);
            if (a) begin
                acc_n++;
                if (first_acc < 0) first_acc = c;
            end
            if (f && first_xfr < 0) first_xfr = c;
        end
        total++;
        if (acc_n != 16) begin
            bad++;
            $display("FAIL b2b_accepts got %0d want 16", acc_n);
        end
        total++;
        if (first_xfr - first_acc != 2) begin
            bad++;
            $display("FAIL b2b_latency got %0d want 2", first_xfr - first_acc);
        end
        total++;
        if (obs_q.size() != 16) begin
            bad++;
            $display("FAIL b2b_count got %0d want 16", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b[%0d] got y=%h co=%b inx=%b want y=%h co=%b inx=%b",
                         i, obs_q[i].y, obs_q[i].co, obs_q[i].inx, exp_q[i].y, exp_q[i].co, exp_q[i].inx);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] tx[4];
        logic [2:0]       tm[4];
        logic             a, f;
        int               idx = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tx[i] = WIDTH'($urandom_range(1, 32'h0FFF_FFFF));
            tm[i] = 3'($urandom_range(7));
        end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, tx[idx], 1'b0, 1'b1, 1'b0, tm[idx], 1'b0, a, f);
            if (a) idx++;
        end
        total++;
        if (idx != 2) begin
            bad++;
            $display("FAIL bp_accepted got %0d want 2", idx);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_in_ready_full got %b want 0", bus.in_ready);
        end
        cycle(1'b1, tx[idx], 1'b0, 1'b1, 1'b0, tm[idx], 1'b1, a, f);
        if (a) idx++;
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_bubble got accept=%b want 1", a);
        end
        for (int c = 0; c < 10 && idx < 4; c++) begin
            cycle(1'b1, tx[idx], 1'b0, 1'b1, 1'b0, tm[idx], 1'b1, a, f);
            if (a) idx++;
        end
        drain();
        total++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL bp_count got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp[%0d] got y=%h inx=%b want y=%h inx=%b",
                         i, obs_q[i].y, obs_q[i].inx, exp_q[i].y, exp_q[i].inx);
            end
        end
        total++;
`ifdef ROUND_INEXACT_CNT_EN
        if (bus.inexact_cnt !== 16'd4) begin
            bad++;
            $display("FAIL bp_cnt got %0d want 4", bus.inexact_cnt);
        end
`else
        if (bus.inexact_cnt !== 16'd0) begin
            bad++;
            $display("FAIL bp_cnt got %0d want 0", bus.inexact_cnt);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        logic a, f;
        int   acc_n = 0;
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < 2; c++) begin
            cycle(1'b1, WIDTH'($urandom_range(1, 1000)), 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, a, f);
            if (a) acc_n++;
        end
        total++;
        if (acc_n != 2) begin
            bad++;
            $display("FAIL mid_inflight got %0d want 2", acc_n);
        end
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_out_valid got %b want 0", bus.out_valid);
        end
        total++;
        if (bus.inexact_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_cnt got %0d want 0", bus.inexact_cnt);
        end
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        cnt_model = 0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_in_ready got %b want 1", bus.in_ready);
        end
        for (int c = 0; c < 10; c++)
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, a, f);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL mid_ghost got %0d results want 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
